// File: rtl/axi_resp_pkg.sv
// Shared AXI response/burst encodings, responder FSM states and the response merge helper.
package axi_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StWdata,
        StWresp,
        StRreq,
        StRdata
    } state_e;

    // Severity order OKAY < SLVERR < DECERR matches the numeric encoding.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_ram_sp.sv
// Single-port DEPTH x 64 RAM with per-byte write enables and a registered read port.
module axi_ram_sp #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    we,
    input  logic          re,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave serving one transaction at a time from a single-port on-chip RAM,
// which it clears after every reset before accepting traffic.
module axi_ram_responder
    import axi_resp_pkg::*;
#(
    parameter int unsigned           ID_WIDTH   = 6,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RAM_SIZE   = 32'h10000,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    o_init_done,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int unsigned DEPTH = int'(RAM_SIZE >> 3);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    prio_w_q, prio_w_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [1:0]              err_q, err_d;
    logic [1:0]              resp_q, resp_d;

    logic [ADDR_WIDTH-1:0]   off, incr, next_addr;
    logic                    beat_dec, last, grant_w, aw_hs, ar_hs;
    logic [1:0]              beat_resp;
    logic [ID_WIDTH-1:0]     a_id;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [7:0]              a_len;
    logic [2:0]              a_size;
    logic [1:0]              a_burst;

    logic [IDX_W-1:0]        ram_addr;
    logic [7:0]              ram_we;
    logic                    ram_re;
    logic [63:0]             ram_wdata, ram_rdata;

    axi_ram_sp #(
        .DEPTH(DEPTH),
        .AW   (IDX_W)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .re   (ram_re),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        off       = addr_q - BASE_ADDR;
        beat_dec  = (off >= RAM_SIZE);
        incr      = ADDR_WIDTH'(1) << size_q;
        next_addr = (burst_q == BURST_FIXED) ? addr_q : (addr_q & ~(incr - ADDR_WIDTH'(1))) + incr;
        last      = (beat_cnt_q == len_q);
        beat_resp = resp_merge(err_q, beat_dec ? RESP_DECERR : RESP_OKAY);
        grant_w   = i_awvalid & (~i_arvalid | prio_w_q);
        a_id      = grant_w ? i_awid    : i_arid;
        a_addr    = grant_w ? i_awaddr  : i_araddr;
        a_len     = grant_w ? i_awlen   : i_arlen;
        a_size    = grant_w ? i_awsize  : i_arsize;
        a_burst   = grant_w ? i_awburst : i_arburst;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        prio_w_d    = prio_w_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        resp_d      = resp_q;
        ram_addr    = IDX_W'(off >> 3);
        ram_we      = '0;
        ram_re      = 1'b0;
        ram_wdata   = i_wdata;
        aw_hs       = 1'b0;
        ar_hs       = 1'b0;
        o_wready    = 1'b0;

        unique case (state_q)
            StInit: begin
                ram_addr   = init_cnt_q;
                ram_we     = '1;
                ram_wdata  = '0;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                init_done_d = 1'b1;
                // Traffic is held off for the single IDLE cycle before init_done is visible.
                if (init_done_q) begin
                    aw_hs = i_awvalid & grant_w;
                    ar_hs = i_arvalid & ~grant_w;
                end
                if (aw_hs || ar_hs) begin
                    id_d       = a_id;
                    addr_d     = a_addr;
                    len_d      = a_len;
                    size_d     = a_size;
                    burst_d    = a_burst;
                    beat_cnt_d = '0;
                    err_d      = (a_burst[1] || a_size > 3'd3) ? RESP_SLVERR : RESP_OKAY;
                    resp_d     = err_d;
                    state_d    = aw_hs ? StWdata : StRreq;
                end
            end
            StWdata: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    if (beat_resp == RESP_OKAY) begin
                        ram_we = i_wstrb;
                    end
                    resp_d = resp_merge(resp_merge(resp_q, beat_resp),
                                        (i_wlast != last) ? RESP_SLVERR : RESP_OKAY);
                    addr_d     = next_addr;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                if (i_bready) begin
                    prio_w_d = ~prio_w_q;
                    state_d  = StIdle;
                end
            end
            StRreq: begin
                ram_re  = ~beat_dec;
                state_d = StRdata;
            end
            StRdata: begin
                if (i_rready) begin
                    if (last) begin
                        prio_w_d = ~prio_w_q;
                        state_d  = StIdle;
                    end else begin
                        addr_d     = next_addr;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        state_d    = StRreq;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            prio_w_q    <= 1'b1;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            err_q       <= RESP_OKAY;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            prio_w_q    <= prio_w_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            resp_q      <= resp_d;
        end
    end

    // The RAM read register is not touched in RDATA, so the data holds through stalls.
    always_comb begin
        o_init_done = init_done_q;
        o_awready   = aw_hs;
        o_arready   = ar_hs;
        o_bvalid    = (state_q == StWresp);
        o_bid       = id_q;
        o_bresp     = resp_q;
        o_rvalid    = (state_q == StRdata);
        o_rid       = id_q;
        o_rresp     = o_rvalid ? beat_resp : RESP_OKAY;
        o_rlast     = o_rvalid & last;
        o_rdata     = (o_rvalid && beat_resp == RESP_OKAY) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder with a 256-byte RAM.
module tb_axi_ram_responder;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_init_done;
    logic [5:0]  i_awid, i_arid, o_bid, o_rid;
    logic [31:0] i_awaddr, i_araddr;
    logic [7:0]  i_awlen, i_arlen, i_wstrb;
    logic [2:0]  i_awsize, i_arsize;
    logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
    logic        i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
    logic        i_arvalid, o_arready, o_rlast, o_rvalid, i_rready;
    logic [63:0] i_wdata, o_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] wd [4];
    logic [7:0]  ws [4];
    logic [63:0] ed [4];
    logic [1:0]  er [4];

    logic [5:0]  bid;
    logic [1:0]  bresp;
    int          blat;
    int          n;

    axi_ram_responder #(
        .ID_WIDTH  (6),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64),
        .RAM_SIZE  (32'h100),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .o_init_done(o_init_done),
        .i_awid     (i_awid),
        .i_awaddr   (i_awaddr),
        .i_awlen    (i_awlen),
        .i_awsize   (i_awsize),
        .i_awburst  (i_awburst),
        .i_awvalid  (i_awvalid),
        .o_awready  (o_awready),
        .i_wdata    (i_wdata),
        .i_wstrb    (i_wstrb),
        .i_wlast    (i_wlast),
        .i_wvalid   (i_wvalid),
        .o_wready   (o_wready),
        .o_bid      (o_bid),
        .o_bresp    (o_bresp),
        .o_bvalid   (o_bvalid),
        .i_bready   (i_bready),
        .i_arid     (i_arid),
        .i_araddr   (i_araddr),
        .i_arlen    (i_arlen),
        .i_arsize   (i_arsize),
        .i_arburst  (i_arburst),
        .i_arvalid  (i_arvalid),
        .o_arready  (o_arready),
        .o_rid      (o_rid),
        .o_rdata    (o_rdata),
        .o_rresp    (o_rresp),
        .o_rlast    (o_rlast),
        .o_rvalid   (o_rvalid),
        .i_rready   (i_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return o_awready;
            1:       return o_wready;
            2:       return o_bvalid;
            3:       return o_arready;
            default: return o_rvalid;
        endcase
    endfunction

    // Entered at a falling edge; returns just after a falling edge with the signal high.
    task automatic wait_sig(input int which, output int cnt);
        cnt = 0;
        #1;
        while (!sig_of(which) && cnt < TMO) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= TMO) chk($sformatf("timeout_sig%0d", which), 64'(cnt), 64'(0));
    endtask

    task automatic init_check(input string tag);
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (i == 32) chk({tag, "_done_early"}, 64'(o_init_done), 64'(0));
        end
        chk({tag, "_done"}, 64'(o_init_done), 64'(1));
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             output logic [5:0] rbid, output logic [1:0] rbresp, output int lat);
        int c;
        i_awid    = id;
        i_awaddr  = addr;
        i_awlen   = len;
        i_awsize  = size;
        i_awburst = burst;
        i_awvalid = 1'b1;
        wait_sig(0, c);
        @(negedge clk);
        i_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            i_wdata  = wd[b];
            i_wstrb  = ws[b];
            i_wlast  = (b == int'(len));
            i_wvalid = 1'b1;
            wait_sig(1, c);
            @(negedge clk);
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
        i_bready = 1'b1;
        wait_sig(2, lat);
        rbid   = o_bid;
        rbresp = o_bresp;
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall,
                            input string tag);
        int c;
        i_arid    = id;
        i_araddr  = addr;
        i_arlen   = len;
        i_arsize  = size;
        i_arburst = burst;
        i_arvalid = 1'b1;
        wait_sig(3, c);
        @(negedge clk);
        i_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            i_rready = !stall;
            wait_sig(4, c);
            chk($sformatf("%s_lat%0d", tag, b), 64'(c), 64'(1));
            chk($sformatf("%s_rdata%0d", tag, b), o_rdata, ed[b]);
            chk($sformatf("%s_rresp%0d", tag, b), 64'(o_rresp), 64'(er[b]));
            chk($sformatf("%s_rlast%0d", tag, b), 64'(o_rlast), 64'(b == int'(len)));
            chk($sformatf("%s_rid%0d", tag, b), 64'(o_rid), 64'(id));
            if (stall) begin
                @(negedge clk);
                #1;
                chk($sformatf("%s_stall_rvalid%0d", tag, b), 64'(o_rvalid), 64'(1));
                chk($sformatf("%s_stall_rdata%0d", tag, b), o_rdata, ed[b]);
                i_rready = 1'b1;
            end
            @(negedge clk);
        end
        i_rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst} = '0;
        {i_arid, i_araddr, i_arlen, i_arsize, i_arburst} = '0;
        {i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready, i_rready} = '0;
        i_awvalid = 1'b1;
        i_arvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_init_done", 64'(o_init_done), 64'(0));
        chk("rst_awready", 64'(o_awready), 64'(0));
        chk("rst_arready", 64'(o_arready), 64'(0));
        chk("rst_bvalid", 64'(o_bvalid), 64'(0));
        chk("rst_rvalid", 64'(o_rvalid), 64'(0));
        chk("rst_rdata", o_rdata, 64'(0));
        i_awvalid = 1'b0;
        i_arvalid = 1'b0;
        @(negedge clk);
        init_check("init");

        // Cleared memory
        ed[0] = 64'h0;
        er[0] = 2'b00;
        axi_read(6'd1, 32'h08, 8'd0, 3'd3, 2'b01, 1'b0, "rd08");

        // Single full-width beat
        wd[0] = 64'h0123456789ABCDEF;
        ws[0] = 8'hFF;
        axi_write(6'd5, 32'h10, 8'd0, 3'd3, 2'b01, bid, bresp, blat);
        chk("wr10_bid", 64'(bid), 64'(5));
        chk("wr10_bresp", 64'(bresp), 64'(0));
        chk("wr10_blat", 64'(blat), 64'(0));
        ed[0] = 64'h0123456789ABCDEF;
        axi_read(6'd5, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0, "rd10");

        // INCR burst of 4, read back with stalls
        wd[0] = 64'h1111111111111111;
        wd[1] = 64'h2222222222222222;
        wd[2] = 64'h3333333333333333;
        wd[3] = 64'h4444444444444444;
        for (int i = 0; i < 4; i++) begin
            ws[i] = 8'hFF;
            ed[i] = wd[i];
            er[i] = 2'b00;
        end
        axi_write(6'd2, 32'h20, 8'd3, 3'd3, 2'b01, bid, bresp, blat);
        chk("wr20_bid", 64'(bid), 64'(2));
        chk("wr20_bresp", 64'(bresp), 64'(0));
        axi_read(6'd3, 32'h20, 8'd3, 3'd3, 2'b01, 1'b1, "rd20");

        // Narrow byte write into lane 3 of the word at 0x30
        wd[0] = 64'h00000000_A5000000;
        ws[0] = 8'h08;
        axi_write(6'd7, 32'h33, 8'd0, 3'd0, 2'b01, bid, bresp, blat);
        chk("wr33_bresp", 64'(bresp), 64'(0));
        ed[0] = 64'h33333333_A5333333;
        er[0] = 2'b00;
        axi_read(6'd7, 32'h30, 8'd0, 3'd3, 2'b01, 1'b0, "rd30");

        // Out-of-range read
        ed[0] = 64'h0;
        ed[1] = 64'h0;
        er[0] = 2'b11;
        er[1] = 2'b11;
        axi_read(6'd9, 32'h100, 8'd1, 3'd3, 2'b01, 1'b0, "rd100");

        // WRAP write is rejected and must not touch memory
        wd[0] = 64'hDEADBEEFDEADBEEF;
        wd[1] = 64'hCAFEF00DCAFEF00D;
        ws[0] = 8'hFF;
        ws[1] = 8'hFF;
        axi_write(6'd4, 32'h10, 8'd1, 3'd3, 2'b10, bid, bresp, blat);
        chk("wrap_bid", 64'(bid), 64'(4));
        chk("wrap_bresp", 64'(bresp), 64'(2));
        ed[0] = 64'h0123456789ABCDEF;
        er[0] = 2'b00;
        axi_read(6'd4, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0, "rdwrap");

        // Simultaneous AW/AR to the same word: write wins, read sees new data
        for (int k = 0; k < 2; k++) begin
            i_arid    = 6'd10;
            i_araddr  = 32'h48 + 32'(k * 8);
            i_arlen   = 8'd0;
            i_arsize  = 3'd3;
            i_arburst = 2'b01;
            i_arvalid = 1'b1;
            i_awid    = 6'd11;
            i_awaddr  = 32'h48 + 32'(k * 8);
            i_awlen   = 8'd0;
            i_awsize  = 3'd3;
            i_awburst = 2'b01;
            i_awvalid = 1'b1;
            #1;
            chk($sformatf("both%0d_awready", k), 64'(o_awready), 64'(1));
            chk($sformatf("both%0d_arready", k), 64'(o_arready), 64'(0));
            wd[0] = 64'hA0A0A0A0_00000000 + 64'(k + 1);
            ws[0] = 8'hFF;
            axi_write(6'd11, 32'h48 + 32'(k * 8), 8'd0, 3'd3, 2'b01, bid, bresp, blat);
            chk($sformatf("both%0d_bresp", k), 64'(bresp), 64'(0));
            ed[0] = 64'hA0A0A0A0_00000000 + 64'(k + 1);
            er[0] = 2'b00;
            axi_read(6'd10, 32'h48 + 32'(k * 8), 8'd0, 3'd3, 2'b01, 1'b0,
                     $sformatf("both%0d", k));
        end

        // Reset in the middle of a read burst
        i_arid    = 6'd1;
        i_araddr  = 32'h20;
        i_arlen   = 8'd3;
        i_arsize  = 3'd3;
        i_arburst = 2'b01;
        i_arvalid = 1'b1;
        wait_sig(3, n);
        @(negedge clk);
        i_arvalid = 1'b0;
        i_rready  = 1'b1;
        wait_sig(4, n);
        @(negedge clk);
        wait_sig(4, n);
        chk("mid_rvalid_pre", 64'(o_rvalid), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rvalid", 64'(o_rvalid), 64'(0));
        chk("mid_init_done", 64'(o_init_done), 64'(0));
        i_rready = 1'b0;
        @(negedge clk);
        init_check("reinit");
        ed[0] = 64'h0;
        er[0] = 2'b00;
        axi_read(6'd2, 32'h20, 8'd0, 3'd3, 2'b01, 1'b0, "rdclr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
